// File: rtl/system_bus_arbiter.sv
// Two-master round-robin front end for the system bus.
// Outstanding reads are tagged in order so each response returns to its issuer.
module system_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               m0_ready,
    input  logic [29:0]                        m0_addr,
    input  logic [31:0]                        m0_write_data,
    input  logic [3:0]                         m0_byte_enable,
    input  logic                               m0_write_req,
    input  logic                               m0_read_req,
    output logic [31:0]                        m0_read_data,
    output logic                               m0_read_data_valid,
    output logic                               m1_ready,
    input  logic [29:0]                        m1_addr,
    input  logic [31:0]                        m1_write_data,
    input  logic [3:0]                         m1_byte_enable,
    input  logic                               m1_write_req,
    input  logic                               m1_read_req,
    output logic [31:0]                        m1_read_data,
    output logic                               m1_read_data_valid,
    input  logic                               bus_ready,
    output logic [29:0]                        bus_addr,
    output logic [31:0]                        bus_write_data,
    output logic [3:0]                         bus_byte_enable,
    output logic                               bus_write_req,
    output logic                               bus_read_req,
    input  logic [31:0]                        bus_read_data,
    input  logic                               bus_read_data_valid,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               protocol_error
);

    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

    logic                       prio_q, prio_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       perr_q, perr_d;

    logic m0_req, m1_req, sel, sel_wr, sel_rd;
    logic fifo_full, fifo_empty, accept, push, pop, head;

    assign m0_req = m0_write_req | m0_read_req;
    assign m1_req = m1_write_req | m1_read_req;

    always_comb begin
        sel = prio_q;
        if (m0_req && !m1_req) sel = 1'b0;
        else if (m1_req && !m0_req) sel = 1'b1;
    end

    assign sel_wr          = sel ? m1_write_req   : m0_write_req;
    assign sel_rd          = sel ? m1_read_req    : m0_read_req;
    assign bus_addr        = sel ? m1_addr        : m0_addr;
    assign bus_write_data  = sel ? m1_write_data  : m0_write_data;
    assign bus_byte_enable = sel ? m1_byte_enable : m0_byte_enable;

    // Full is judged on the registered count only; a coincident pop does not free a slot.
    assign fifo_full  = (count_q == FULL);
    assign fifo_empty = (count_q == '0);

    assign bus_write_req = ~reset & sel_wr;
    assign bus_read_req  = ~reset & sel_rd & ~sel_wr & ~fifo_full;

    assign accept   = bus_ready & (bus_write_req | bus_read_req);
    assign m0_ready = accept & ~sel;
    assign m1_ready = accept & sel;

    assign push = accept & bus_read_req;
    assign pop  = ~reset & bus_read_data_valid & ~fifo_empty;
    assign head = fifo_q[rd_ptr_q];

    assign m0_read_data_valid = pop & ~head;
    assign m1_read_data_valid = pop & head;
    assign m0_read_data       = bus_read_data;
    assign m1_read_data       = bus_read_data;

    assign outstanding    = count_q;
    assign protocol_error = perr_q;

    always_comb begin
        prio_d   = prio_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        perr_d   = perr_q;
        if (accept) prio_d = ~sel;
        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (bus_read_data_valid && fifo_empty) perr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= 1'b0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            perr_q   <= perr_d;
        end
    end

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Directed bench for system_bus_arbiter.
// Inputs change 1 ns after posedge; outputs are checked just after that.
module tb_system_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_ready, m1_ready;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_write_data, m1_write_data;
    logic [3:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_data_valid, m1_read_data_valid;
    logic        bus_ready;
    logic [29:0] bus_addr;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_write_req, bus_read_req;
    logic [31:0] bus_read_data;
    logic        bus_read_data_valid;
    logic [2:0]  outstanding;
    logic        protocol_error;

    int tests = 0;
    int fails = 0;
    bit done  = 0;

    system_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_write_data(m0_write_data), .m0_byte_enable(m0_byte_enable),
        .m0_write_req(m0_write_req), .m0_read_req(m0_read_req),
        .m0_read_data(m0_read_data), .m0_read_data_valid(m0_read_data_valid),
        .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_write_data(m1_write_data), .m1_byte_enable(m1_byte_enable),
        .m1_write_req(m1_write_req), .m1_read_req(m1_read_req),
        .m1_read_data(m1_read_data), .m1_read_data_valid(m1_read_data_valid),
        .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
        .bus_write_req(bus_write_req), .bus_read_req(bus_read_req),
        .bus_read_data(bus_read_data), .bus_read_data_valid(bus_read_data_valid),
        .outstanding(outstanding), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL timeout: bench still running after %0d cycles", n);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic chk(input string tag, input bit ok);
        tests++;
        if (!ok) begin
            fails++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m0_write_req = 0; m0_read_req = 0;
        m1_write_req = 0; m1_read_req = 0;
        bus_read_data_valid = 0;
    endtask

    initial begin
        logic [31:0] rdata [4];
        logic        rown  [4];
        rdata[0] = 32'hA0A0_0001; rdata[1] = 32'hB0B0_0002;
        rdata[2] = 32'hC0C0_0003; rdata[3] = 32'hD0D0_0004;
        rown[0] = 0; rown[1] = 1; rown[2] = 1; rown[3] = 0;

        reset = 1; bus_ready = 1; bus_read_data = 0;
        m0_addr = 30'h111; m1_addr = 30'h222;
        m0_write_data = 32'h1111_1111; m1_write_data = 32'h2222_2222;
        m0_byte_enable = 4'hF; m1_byte_enable = 4'h3;
        clr();
        tick(); tick();

        m0_write_req = 1; bus_read_data_valid = 1; #1;
        chk("rst_bus_wr", bus_write_req === 1'b0);
        chk("rst_m0_ready", m0_ready === 1'b0);
        chk("rst_m0_rdv", m0_read_data_valid === 1'b0);
        tick(); clr(); reset = 0; #1;
        tests++;
        if (outstanding !== 3'd0 || protocol_error !== 1'b0) begin
            fails++;
            $error("FAIL rst_state outstanding=%0h perr=%0h expected 0/0",
                   outstanding, protocol_error);
        end
        chk("rst_outstanding", outstanding === 3'd0);
        chk("rst_perr", protocol_error === 1'b0);

        m0_addr = 30'h40; m0_read_req = 1; #1;
        chk("t1_m0_ready", m0_ready === 1'b1);
        chk("t1_bus_rd", bus_read_req === 1'b1);
        chk("t1_bus_addr", bus_addr === 30'h40);
        tick(); clr(); #1;
        chk("t1_out1", outstanding === 3'd1);
        bus_read_data = 32'hDEAD_BEEF; bus_read_data_valid = 1; #1;
        chk("t1_m0_rdv", m0_read_data_valid === 1'b1);
        chk("t1_m1_rdv", m1_read_data_valid === 1'b0);
        chk("t1_m0_data", m0_read_data === 32'hDEAD_BEEF);
        tick(); clr(); #1;
        chk("t1_out0", outstanding === 3'd0);

        reset = 1; tick(); reset = 0;
        m0_addr = 30'h111; m0_write_req = 1; m1_write_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("c_m0_ready", m0_ready === (i % 2 == 0));
            chk("c_m1_ready", m1_ready === (i % 2 == 1));
            chk("c_bus_addr",
                bus_addr === ((i % 2 == 0) ? 30'h111 : 30'h222));
            tick();
        end
        clr();

        for (int i = 0; i < 4; i++) begin
            m0_read_req = (i % 2 == 0); m1_read_req = (i % 2 == 1); #1;
            chk("f_fill_acc", (m0_ready | m1_ready) === 1'b1);
            tick();
        end
        clr(); #1;
        chk("f_out4", outstanding === 3'd4);
        m0_write_req = 1; m1_read_req = 1; #1;
        chk("f_m0_wr_ready", m0_ready === 1'b1);
        chk("f_m1_held", m1_ready === 1'b0);
        chk("f_bus_rd0", bus_read_req === 1'b0);
        tick(); m0_write_req = 0;
        bus_read_data = 32'h5555_0000; bus_read_data_valid = 1; #1;
        chk("f_stall_pop", m1_ready === 1'b0);
        chk("f_pop_m0", m0_read_data_valid === 1'b1);
        tick(); bus_read_data_valid = 0; #1;
        chk("f_out3", outstanding === 3'd3);
        chk("f_m1_acc", m1_ready === 1'b1);
        tick(); clr(); #1;
        chk("f_out4b", outstanding === 3'd4);
        for (int i = 0; i < 4; i++) begin
            bus_read_data_valid = 1; bus_read_data = 32'h6000 + i; #1;
            chk("f_drain_m1", m1_read_data_valid === (i != 1));
            chk("f_drain_m0", m0_read_data_valid === (i == 1));
            tick();
        end
        clr(); #1;
        chk("f_out0", outstanding === 3'd0);

        for (int i = 0; i < 4; i++) begin
            m0_read_req = (rown[i] == 0); m1_read_req = (rown[i] == 1); #1;
            chk("i_issue", bus_read_req === 1'b1);
            tick();
        end
        clr();
        for (int i = 0; i < 4; i++) begin
            bus_read_data_valid = 1; bus_read_data = rdata[i]; #1;
            chk("i_m0_rdv", m0_read_data_valid === (rown[i] == 0));
            chk("i_m1_rdv", m1_read_data_valid === (rown[i] == 1));
            chk("i_data",
                (rown[i] ? m1_read_data : m0_read_data) === rdata[i]);
            tick();
        end
        clr();

        bus_ready = 0; m0_write_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b_m0_ready", m0_ready === 1'b0);
            chk("b_bus_wr", bus_write_req === 1'b1);
            tick();
        end
        m1_write_req = 1; #1;
        chk("b_ptr_held", bus_addr === 30'h222);
        tick(); m1_write_req = 0; bus_ready = 1; #1;
        chk("b_accept", m0_ready === 1'b1);
        tick(); clr(); #1;
        chk("b_single", (m0_ready | bus_write_req) === 1'b0);

        bus_read_data_valid = 1; #1;
        chk("e_m0_rdv", m0_read_data_valid === 1'b0);
        chk("e_m1_rdv", m1_read_data_valid === 1'b0);
        tick(); clr(); #1;
        chk("e_perr", protocol_error === 1'b1);
        m0_read_req = 1; tick(); tick(); clr(); #1;
        chk("e_perr_held", protocol_error === 1'b1);
        chk("e_out2", outstanding === 3'd2);
        reset = 1; tick(); reset = 0; #1;
        chk("e_rst_out", outstanding === 3'd0);
        chk("e_rst_perr", protocol_error === 1'b0);

        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
